// File: rtl/hex_scroller_if.sv
// hex_scroller_if
//   Groups the switch/button inputs and the display outputs of hex_scroller
//   into one bundle. Clock and reset are kept outside as plain ports.
//
//   Signals:
//     SW    [2:0]            character code to load
//     load                   write strobe, one write per cycle it is high
//     clear                  synchronous clear of buffer, offset and wr_ptr
//     pause                  1 = hold scroll position
//     dir                    0 = scroll left, 1 = scroll right
//     LEDR  [2:0]            registered copy of SW
//     tick                   one-cycle pulse at each prescaler terminal count
//     HEX   [7*NUM_DIGITS-1:0] active-low segments, digit 0 rightmost
//
//   Handshake: there is no valid/ready pair. load is a plain strobe that is
//   sampled on every rising clock edge; the design is always ready, so each
//   cycle with load = 1 (and clear = 0) performs exactly one write.
//
//   Modports: master = board/test side (drives controls), slave = hex_scroller.

interface hex_scroller_if #(
    parameter int NUM_DIGITS = 6
);
    logic [2:0]              SW;
    logic                    load;
    logic                    clear;
    logic                    pause;
    logic                    dir;
    logic [2:0]              LEDR;
    logic                    tick;
    logic [7*NUM_DIGITS-1:0] HEX;

    modport master (
        output SW, load, clear, pause, dir,
        input  LEDR, tick, HEX
    );

    modport slave (
        input  SW, load, clear, pause, dir,
        output LEDR, tick, HEX
    );
endinterface

// File: rtl/hex_scroller.sv
// hex_scroller
//   Circular message buffer of 3-bit character codes, shown as a NUM_DIGITS
//   wide window on active-low seven-segment displays. The window scrolls left
//   or right once per prescaler tick unless paused; characters can be loaded
//   at run time from the switches, and the buffer can be cleared.
//
//   Ports:
//     CLOCK_50  in   system clock, rising edge
//     Resetn    in   asynchronous active-low reset
//     bus       slave modport of hex_scroller_if (SW, load, clear, pause,
//               dir in; LEDR, tick, HEX out)
//
//   Parameters:
//     NUM_DIGITS  digits driven (1..8)
//     MSG_LEN     buffer entries (NUM_DIGITS..32)
//     TICK_DIV    clock cycles per scroll tick (>= 2)
//
//   Optional feature macro: PAUSE_BLINK_EN
//     When defined, the display blinks (blank / window, toggling on each
//     tick) while pause is held.

module hex_scroller #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 25000000
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    hex_scroller_if.slave bus
);

    localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [2:0]    CODE_BLANK = 3'd4;
    localparam logic [PW-1:0] LAST_SLOT  = PW'(MSG_LEN - 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);
    localparam logic [PW:0]   LEN_WIDE   = (PW+1)'(MSG_LEN);

    logic [CW-1:0]           count;
    logic                    tick_w;
    logic [PW-1:0]           offset;
    logic [PW-1:0]           wr_ptr;
    logic [2:0]              buffer [MSG_LEN];
    logic [PW:0]             slot;
    logic [7*NUM_DIGITS-1:0] window;
    logic [7*NUM_DIGITS-1:0] hex_next;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic [2:0]              ledr_q;

    // Power-on message "HELLO" followed by blanks.
    function automatic logic [2:0] reset_code(input int idx);
        case (idx)
            0:       reset_code = 3'd0;
            1:       reset_code = 3'd1;
            2:       reset_code = 3'd2;
            3:       reset_code = 3'd2;
            4:       reset_code = 3'd3;
            default: reset_code = CODE_BLANK;
        endcase
    endfunction

    // Active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [2:0] code);
        case (code)
            3'd0:    glyph = 7'b0001001; // H
            3'd1:    glyph = 7'b0000110; // E
            3'd2:    glyph = 7'b1000111; // L
            3'd3:    glyph = 7'b1000000; // O
            default: glyph = 7'b1111111; // blank
        endcase
    endfunction

    // Prescaler: free-running, only reset clears it (pause and clear do not).
    assign tick_w = (count == LAST_COUNT);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
        end else if (tick_w) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Offset and write pointer. Clear wins over both load and scroll;
    // otherwise a load and a scroll step in the same cycle both apply.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            offset <= '0;
            wr_ptr <= '0;
        end else if (bus.clear) begin
            offset <= '0;
            wr_ptr <= '0;
        end else begin
            if (bus.load) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (tick_w && !bus.pause) begin
                if (bus.dir) begin
                    offset <= (offset == '0) ? LAST_SLOT : offset - 1'b1;
                end else begin
                    offset <= (offset == LAST_SLOT) ? '0 : offset + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buffer[i] <= reset_code(i);
            end
        end else if (bus.clear) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buffer[i] <= CODE_BLANK;
            end
        end else if (bus.load) begin
            buffer[wr_ptr] <= bus.SW;
        end
    end

    // Window: leftmost digit (NUM_DIGITS-1) shows buffer[offset]. The sum
    // offset + (NUM_DIGITS-1-k) is below 2*MSG_LEN, so one conditional
    // subtract is enough for the modulo.
    always_comb begin
        window = '1;
        slot   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            slot = {1'b0, offset} + (PW+1)'(NUM_DIGITS - 1 - k);
            if (slot >= LEN_WIDE) begin
                slot = slot - LEN_WIDE;
            end
            window[7*k +: 7] = glyph(buffer[slot[PW-1:0]]);
        end
    end

`ifdef PAUSE_BLINK_EN
    logic blink;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            blink <= 1'b0;
        end else if (!bus.pause) begin
            blink <= 1'b0;
        end else if (tick_w) begin
            blink <= ~blink;
        end
    end

    assign hex_next = blink ? '1 : window;
`else
    assign hex_next = window;
`endif

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            hex_q  <= '1;
            ledr_q <= '0;
        end else begin
            hex_q  <= hex_next;
            ledr_q <= bus.SW;
        end
    end

    assign bus.HEX  = hex_q;
    assign bus.LEDR = ledr_q;
    assign bus.tick = tick_w;

endmodule
